// File: rtl/cvxif_issue_ctrl_if.sv
// Coprocessor-side issue/result channel of cvxif_issue_ctrl.
// master = the issue controller, slave = the coprocessor.
interface cvxif_issue_ctrl_if #(
   parameter int NR_IDS = 4,
   parameter int XLEN   = 32
);
   logic                        x_issue_valid_o;
   logic [31:0]                 x_issue_instr_o;
   logic [$clog2(NR_IDS)-1:0]   x_issue_id_o;
   logic [3*XLEN-1:0]           x_issue_rs_o;
   logic [2:0]                  x_issue_rs_valid_o;
   logic                        x_issue_ready_i;
   logic                        x_issue_accept_i;
   logic                        x_issue_writeback_i;
   logic [2:0]                  x_issue_register_read_i;
   logic                        x_result_valid_i;
   logic [$clog2(NR_IDS)-1:0]   x_result_id_i;
   logic [XLEN-1:0]             x_result_data_i;
   logic [4:0]                  x_result_rd_i;
   logic                        x_result_we_i;
   logic                        x_result_ready_o;

   modport master (
      output x_issue_valid_o, x_issue_instr_o, x_issue_id_o, x_issue_rs_o,
             x_issue_rs_valid_o, x_result_ready_o,
      input  x_issue_ready_i, x_issue_accept_i, x_issue_writeback_i,
             x_issue_register_read_i, x_result_valid_i, x_result_id_i,
             x_result_data_i, x_result_rd_i, x_result_we_i
   );

   modport slave (
      input  x_issue_valid_o, x_issue_instr_o, x_issue_id_o, x_issue_rs_o,
             x_issue_rs_valid_o, x_result_ready_o,
      output x_issue_ready_i, x_issue_accept_i, x_issue_writeback_i,
             x_issue_register_read_i, x_result_valid_i, x_result_id_i,
             x_result_data_i, x_result_rd_i, x_result_we_i
   );
endinterface

// File: rtl/cvxif_issue_ctrl.sv
// Issues offloaded instructions to a coprocessor, tracks outstanding IDs and forwards results.
// Optional issue timeout is enabled by defining CVXIF_ISSUE_TIMEOUT_EN.
module cvxif_issue_ctrl #(
   parameter int NR_IDS = 4,
   parameter int XLEN   = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          instr_valid_i,
   input  logic [31:0]                   instr_i,
   input  logic [XLEN-1:0]               rs1_i,
   input  logic [XLEN-1:0]               rs2_i,
   input  logic [XLEN-1:0]               rs3_i,
   output logic                          instr_ready_o,
   cvxif_issue_ctrl_if.master            xif,
   output logic                          wb_valid_o,
   output logic [XLEN-1:0]               wb_data_o,
   output logic [4:0]                    wb_rd_o,
   output logic [$clog2(NR_IDS)-1:0]     wb_id_o,
   input  logic                          wb_ready_i,
   output logic                          illegal_o,
   output logic                          spurious_o,
   output logic                          timeout_o,
   output logic [$clog2(NR_IDS+1)-1:0]   outstanding_o,
   output logic                          busy_o
);
   localparam int IDW = $clog2(NR_IDS);
   localparam int CW  = $clog2(NR_IDS+1);

   typedef enum logic {IDLE, ISSUE} state_e;

   state_e              state_q, state_d;
   logic [NR_IDS-1:0]   busy_q, busy_d;
   logic [31:0]         instr_q, instr_d;
   logic [3*XLEN-1:0]   rs_q, rs_d;
   logic [IDW-1:0]      id_q, id_d;
   logic                wb_valid_q, wb_valid_d;
   logic [XLEN-1:0]     wb_data_q, wb_data_d;
   logic [4:0]          wb_rd_q, wb_rd_d;
   logic [IDW-1:0]      wb_id_q, wb_id_d;
   logic                illegal_q, illegal_d;
   logic                spurious_q, spurious_d;
   logic                free_any;
   logic [IDW-1:0]      free_id;
   logic                res_fire, res_hit;
   logic [2:0]          unused_rr;
`ifdef CVXIF_ISSUE_TIMEOUT_EN
   logic [7:0]          cnt_q, cnt_d;
   logic                timeout_q, timeout_d;
`endif

   assign unused_rr = xif.x_issue_register_read_i;

   // Descending scan so the lowest-numbered free ID wins.
   always_comb begin
      free_any = 1'b0;
      free_id  = '0;
      for (int i = NR_IDS-1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_any = 1'b1;
            free_id  = IDW'(i);
         end
      end
   end

   always_comb begin
      outstanding_o = '0;
      for (int i = 0; i < NR_IDS; i++) outstanding_o = outstanding_o + CW'(busy_q[i]);
   end

   assign xif.x_result_ready_o = !wb_valid_q || wb_ready_i;
   assign res_fire             = xif.x_result_valid_i && xif.x_result_ready_o;
   assign res_hit              = busy_q[xif.x_result_id_i];

   always_comb begin
      state_d       = state_q;
      busy_d        = busy_q;
      instr_d       = instr_q;
      rs_d          = rs_q;
      id_d          = id_q;
      wb_valid_d    = wb_valid_q;
      wb_data_d     = wb_data_q;
      wb_rd_d       = wb_rd_q;
      wb_id_d       = wb_id_q;
      illegal_d     = 1'b0;
      spurious_d    = 1'b0;
      instr_ready_o = 1'b0;
`ifdef CVXIF_ISSUE_TIMEOUT_EN
      cnt_d         = cnt_q;
      timeout_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            instr_ready_o = free_any;
            if (instr_valid_i && free_any) begin
               instr_d = instr_i;
               rs_d    = {rs3_i, rs2_i, rs1_i};
               id_d    = free_id;
               state_d = ISSUE;
`ifdef CVXIF_ISSUE_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         ISSUE: begin
            if (xif.x_issue_ready_i) begin
               state_d = IDLE;
               if (!xif.x_issue_accept_i)      illegal_d    = 1'b1;
               else if (xif.x_issue_writeback_i) busy_d[id_q] = 1'b1;
            end
`ifdef CVXIF_ISSUE_TIMEOUT_EN
            else if (cnt_q == 8'd254) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      // The issuing ID is never busy, so this clear cannot collide with the set above.
      if (res_fire) begin
         if (res_hit) begin
            busy_d[xif.x_result_id_i] = 1'b0;
            if (xif.x_result_we_i) begin
               wb_valid_d = 1'b1;
               wb_data_d  = xif.x_result_data_i;
               wb_rd_d    = xif.x_result_rd_i;
               wb_id_d    = xif.x_result_id_i;
            end else if (wb_ready_i) begin
               wb_valid_d = 1'b0;
            end
         end else begin
            spurious_d = 1'b1;
            if (wb_ready_i) wb_valid_d = 1'b0;
         end
      end else if (wb_ready_i) begin
         wb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         busy_q     <= '0;
         instr_q    <= '0;
         rs_q       <= '0;
         id_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_data_q  <= '0;
         wb_rd_q    <= '0;
         wb_id_q    <= '0;
         illegal_q  <= 1'b0;
         spurious_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         instr_q    <= instr_d;
         rs_q       <= rs_d;
         id_q       <= id_d;
         wb_valid_q <= wb_valid_d;
         wb_data_q  <= wb_data_d;
         wb_rd_q    <= wb_rd_d;
         wb_id_q    <= wb_id_d;
         illegal_q  <= illegal_d;
         spurious_q <= spurious_d;
      end
   end

`ifdef CVXIF_ISSUE_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

   assign xif.x_issue_valid_o    = (state_q == ISSUE);
   assign xif.x_issue_instr_o    = instr_q;
   assign xif.x_issue_id_o       = id_q;
   assign xif.x_issue_rs_o       = rs_q;
   assign xif.x_issue_rs_valid_o = (state_q == ISSUE) ? 3'b111 : 3'b000;
   assign wb_valid_o             = wb_valid_q;
   assign wb_data_o              = wb_data_q;
   assign wb_rd_o                = wb_rd_q;
   assign wb_id_o                = wb_id_q;
   assign illegal_o              = illegal_q;
   assign spurious_o             = spurious_q;
   assign busy_o                 = (state_q == ISSUE) || (|busy_q) || wb_valid_q;
endmodule

// File: tb/tb_cvxif_issue_ctrl.sv
// Directed scenarios plus random traffic, checked every cycle against a transaction-level model.
module tb_cvxif_issue_ctrl;
   localparam int NR_IDS = 4;
   localparam int XLEN   = 32;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        instr_valid_i;
   logic [31:0] instr_i;
   logic [31:0] rs1_i, rs2_i, rs3_i;
   logic        instr_ready_o;
   logic        wb_valid_o;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_rd_o;
   logic [1:0]  wb_id_o;
   logic        wb_ready_i;
   logic        illegal_o, spurious_o, timeout_o, busy_o;
   logic [2:0]  outstanding_o;

   int n_tests = 0;
   int n_fail  = 0;

   cvxif_issue_ctrl_if #(.NR_IDS(NR_IDS), .XLEN(XLEN)) xif ();

   cvxif_issue_ctrl #(.NR_IDS(NR_IDS), .XLEN(XLEN)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .instr_valid_i(instr_valid_i), .instr_i(instr_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i), .instr_ready_o(instr_ready_o),
      .xif(xif),
      .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
      .wb_id_o(wb_id_o), .wb_ready_i(wb_ready_i),
      .illegal_o(illegal_o), .spurious_o(spurious_o), .timeout_o(timeout_o),
      .outstanding_o(outstanding_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // Reference model: outstanding ID set, one pending issue, one writeback slot.
   bit          m_iss;
   logic [31:0] m_instr;
   logic [95:0] m_rs;
   int          m_id;
   int          m_wait;
   bit          m_busy [NR_IDS];
   bit          m_wbv;
   logic [31:0] m_wdata;
   int          m_wrd, m_wid;
   bit          m_ill, m_spu, m_to;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int n_busy();
      int n = 0;
      for (int i = 0; i < NR_IDS; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic int lowest_free();
      for (int i = 0; i < NR_IDS; i++) if (!m_busy[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_iss = 0; m_wait = 0; m_wbv = 0; m_ill = 0; m_spu = 0; m_to = 0;
      for (int i = 0; i < NR_IDS; i++) m_busy[i] = 0;
   endtask

   // Inputs are already driven; settle, check outputs, advance model, move to next negedge.
   task automatic step();
      bit exp_rdy, exp_rrdy, loaded;
      bit nb [NR_IDS];
      int rid;
      #1;
      exp_rdy  = !m_iss && (n_busy() < NR_IDS);
      exp_rrdy = !m_wbv || wb_ready_i;
      chk("instr_ready", instr_ready_o, exp_rdy);
      chk("x_issue_valid", xif.x_issue_valid_o, m_iss);
      if (m_iss) begin
         chk("x_issue_instr", xif.x_issue_instr_o, m_instr);
         chk("x_issue_id", xif.x_issue_id_o, m_id);
         chk("x_issue_rs", xif.x_issue_rs_o, m_rs);
         chk("x_issue_rs_valid", xif.x_issue_rs_valid_o, 3'b111);
      end
      chk("x_result_ready", xif.x_result_ready_o, exp_rrdy);
      chk("wb_valid", wb_valid_o, m_wbv);
      if (m_wbv) begin
         chk("wb_data", wb_data_o, m_wdata);
         chk("wb_rd", wb_rd_o, m_wrd);
         chk("wb_id", wb_id_o, m_wid);
      end
      chk("illegal", illegal_o, m_ill);
      chk("spurious", spurious_o, m_spu);
      chk("timeout", timeout_o, m_to);
      chk("outstanding", outstanding_o, n_busy());
      chk("busy", busy_o, m_iss || n_busy() != 0 || m_wbv);

      if (rst_i) begin
         model_reset();
      end else begin
         nb = m_busy;
         m_ill = 0; m_spu = 0; m_to = 0; loaded = 0;
         if (m_iss) begin
            if (xif.x_issue_ready_i) begin
               m_iss = 0;
               if (!xif.x_issue_accept_i) m_ill = 1;
               else if (xif.x_issue_writeback_i) nb[m_id] = 1;
            end else begin
               m_wait++;
`ifdef CVXIF_ISSUE_TIMEOUT_EN
               if (m_wait == 255) begin m_iss = 0; m_to = 1; end
`endif
            end
         end else if (exp_rdy && instr_valid_i) begin
            m_iss = 1; m_wait = 0; m_instr = instr_i;
            m_rs = {rs3_i, rs2_i, rs1_i}; m_id = lowest_free();
         end
         if (xif.x_result_valid_i && exp_rrdy) begin
            rid = int'(xif.x_result_id_i);
            if (m_busy[rid]) begin
               nb[rid] = 0;
               if (xif.x_result_we_i) begin
                  loaded = 1; m_wdata = xif.x_result_data_i;
                  m_wrd = int'(xif.x_result_rd_i); m_wid = rid;
               end
            end else m_spu = 1;
         end
         if (loaded) m_wbv = 1;
         else if (wb_ready_i) m_wbv = 0;
         m_busy = nb;
      end
      @(negedge clk);
   endtask

   task automatic idle_in();
      instr_valid_i = 0; xif.x_issue_ready_i = 0; xif.x_issue_accept_i = 0;
      xif.x_issue_writeback_i = 0; xif.x_result_valid_i = 0; wb_ready_i = 1;
   endtask

   task automatic do_issue(input logic [31:0] ins, input bit acc, input bit wbk);
      instr_valid_i = 1; instr_i = ins;
      rs1_i = $urandom; rs2_i = $urandom; rs3_i = $urandom;
      step();
      instr_valid_i = 0;
      xif.x_issue_ready_i = 1; xif.x_issue_accept_i = acc; xif.x_issue_writeback_i = wbk;
      step();
      xif.x_issue_ready_i = 0;
   endtask

   task automatic do_result(input int id, input logic [31:0] d, input int rd, input bit we);
      xif.x_result_valid_i = 1; xif.x_result_id_i = 2'(id);
      xif.x_result_data_i = d; xif.x_result_rd_i = 5'(rd); xif.x_result_we_i = we;
      step();
      xif.x_result_valid_i = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1; idle_in();
      instr_i = 0; rs1_i = 0; rs2_i = 0; rs3_i = 0;
      xif.x_issue_register_read_i = 3'b111; xif.x_result_id_i = 0;
      xif.x_result_data_i = 0; xif.x_result_rd_i = 0; xif.x_result_we_i = 0;
      repeat (2) @(negedge clk);
      model_reset();
      step();
      rst_i = 0;
      step();

      // Accepted with writeback, then result for ID 0.
      do_issue(32'h0000107B, 1, 1);
      step();
      chk("s1_outstanding", outstanding_o, 1);
      do_result(0, 32'h5, 3, 1);
      chk("s1_wb_data", wb_data_o, 32'h5);
      step();
      // Accepted without writeback, then rejected.
      do_issue(32'h0000007B, 1, 0);
      step();
      do_issue(32'h0000007B, 0, 0);
      chk("s3_illegal", illegal_o, 1);
      step(); step();
      // Fill all IDs, free ID 2, next allocation reuses it.
      for (int k = 0; k < 4; k++) do_issue($urandom, 1, 1);
      step();
      chk("s4_full_ready", instr_ready_o, 0);
      do_result(2, $urandom, 7, 0);
      do_issue($urandom, 1, 1);
      // Drain, then spurious result and a stalled writeback slot.
      for (int k = 0; k < 4; k++) do_result(k, $urandom, k + 1, 1);
      step();
      do_result(1, 32'hdead, 1, 1);
      do_issue($urandom, 1, 1);
      do_result(m_id, 32'hbeef, 9, 1);
      wb_ready_i = 0;
      step(); step();
      chk("s5_rres_ready", xif.x_result_ready_o, 0);
      wb_ready_i = 1;
      step();
      // Reset mid-ISSUE with an outstanding ID; its later result is spurious.
      do_issue($urandom, 1, 1);
      instr_valid_i = 1; instr_i = $urandom;
      step();
      instr_valid_i = 0; rst_i = 1;
      step();
      rst_i = 0;
      step();
      do_result(0, 32'h1234, 2, 1);
      step();
`ifdef CVXIF_ISSUE_TIMEOUT_EN
      instr_valid_i = 1; instr_i = $urandom;
      step();
      instr_valid_i = 0;
      repeat (260) step();
      instr_valid_i = 1;
      step();
      instr_valid_i = 0;
      repeat (20) step();
      rst_i = 1;
      step();
      rst_i = 0;
      step();
`endif

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         instr_valid_i           = ($urandom_range(0, 9) < 6);
         instr_i                 = $urandom;
         rs1_i = $urandom; rs2_i = $urandom; rs3_i = $urandom;
         xif.x_issue_ready_i     = ($urandom_range(0, 1) == 1);
         xif.x_issue_accept_i    = ($urandom_range(0, 9) < 8);
         xif.x_issue_writeback_i = ($urandom_range(0, 9) < 7);
         xif.x_result_valid_i    = ($urandom_range(0, 9) < 5);
         xif.x_result_id_i       = 2'($urandom_range(0, 3));
         xif.x_result_data_i     = $urandom;
         xif.x_result_rd_i       = 5'($urandom);
         xif.x_result_we_i       = ($urandom_range(0, 9) < 8);
         wb_ready_i              = ($urandom_range(0, 9) < 7);
         rst_i                   = ($urandom_range(0, 499) == 0);
         step();
      end
      rst_i = 0; idle_in();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cvxif_issue_ctrl.md
CVXIF_ISSUE_CTRL -- requirements
Module: cvxif_issue_ctrl

Interface
REQ-001 SHALL have parameter NR_IDS, default 4: number of coprocessor instruction IDs that may be outstanding.
REQ-002 SHALL have parameter XLEN, default 32: width of operands and results.
REQ-003 SHALL have port clk_i  in  1  clock; the block uses one clock.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports instr_valid_i in 1, instr_i in 32, rs1_i/rs2_i/rs3_i in XLEN each: upstream offload request.
REQ-006 SHALL have port instr_ready_o  out  1: upstream ready.
REQ-007 SHALL have outputs x_issue_valid_o 1, x_issue_instr_o 32, x_issue_id_o $clog2(NR_IDS), x_issue_rs_o 3*XLEN, x_issue_rs_valid_o 3: issue request to the coprocessor.
REQ-008 SHALL have inputs x_issue_ready_i 1, x_issue_accept_i 1, x_issue_writeback_i 1, x_issue_register_read_i 3: coprocessor issue response.
REQ-009 SHALL have inputs x_result_valid_i 1, x_result_id_i $clog2(NR_IDS), x_result_data_i XLEN, x_result_rd_i 5, x_result_we_i 1, and output x_result_ready_o 1: result channel.
REQ-010 SHALL have outputs wb_valid_o 1, wb_data_o XLEN, wb_rd_o 5, wb_id_o $clog2(NR_IDS), and input wb_ready_i 1: writeback to the core.
REQ-011 SHALL have outputs illegal_o 1, spurious_o 1, timeout_o 1 (single-cycle pulses), outstanding_o $clog2(NR_IDS+1), and busy_o 1.

Function
REQ-012 FSM states SHALL be IDLE and ISSUE.
REQ-013 In IDLE, instr_ready_o SHALL be 1 when at least one ID is free in the registered busy vector; otherwise it SHALL be 0.
REQ-014 On instr_valid_i && instr_ready_o, the block SHALL capture the instruction, operands and the lowest-numbered free ID, then enter ISSUE; x_issue_valid_o SHALL rise the next cycle.
REQ-015 In ISSUE, x_issue_valid_o SHALL be 1 and all x_issue_* outputs SHALL be held stable until x_issue_ready_i; instr_ready_o SHALL be 0.
REQ-016 x_issue_rs_valid_o SHALL be 3'b111 while in ISSUE.
REQ-017 On issue handshake with accept=1 and writeback=1, the block SHALL mark the ID busy and return to IDLE.
REQ-018 On issue handshake with accept=1 and writeback=0, the block SHALL return to IDLE without allocating the ID.
REQ-019 On issue handshake with accept=0, the block SHALL not allocate the ID, SHALL pulse illegal_o on the following cycle, and SHALL return to IDLE.
REQ-020 x_result_ready_o SHALL be (!wb_valid_o || wb_ready_i).
REQ-021 On a result handshake for a busy ID, the block SHALL clear that ID; if x_result_we_i=1, it SHALL load the wb register and set wb_valid_o the next cycle.
REQ-022 On a result handshake for a non-busy ID, the block SHALL drop the result and pulse spurious_o the next cycle.
REQ-023 wb_valid_o SHALL stay 1, with data stable, until wb_ready_i.
REQ-024 When allocation and free occur in the same cycle, the freed ID SHALL become allocatable from the next cycle only; both updates SHALL apply.
REQ-025 outstanding_o SHALL equal the popcount of the busy vector.
REQ-026 busy_o SHALL be (state==ISSUE || outstanding_o!=0 || wb_valid_o).

Reset
REQ-027 On rst_i=1 at a clock edge, the state SHALL become IDLE, the busy vector SHALL clear, and wb_valid_o, x_issue_valid_o, illegal_o, spurious_o and timeout_o SHALL be 0; the timeout counter SHALL clear.
REQ-028 Reset mid-ISSUE SHALL drop x_issue_valid_o without a handshake; results arriving after reset for pre-reset IDs SHALL be treated as spurious.

Configuration
REQ-029 Macro CVXIF_ISSUE_TIMEOUT_EN, when defined, SHALL add an 8-bit counter, cleared on ISSUE entry and incremented each ISSUE cycle without x_issue_ready_i.
REQ-030 With CVXIF_ISSUE_TIMEOUT_EN defined, when the counter reaches 255, the block SHALL drop x_issue_valid_o, pulse timeout_o, allocate no ID, and return to IDLE.
REQ-031 Without CVXIF_ISSUE_TIMEOUT_EN, ISSUE SHALL wait indefinitely and timeout_o SHALL be tied to 0.

Verification
REQ-032 Scenario: issue 0x0000107B with accept=1, writeback=1, then result for ID 0 with data 0x5, rd=3 -> wb_valid_o with wb_data_o=0x5, wb_rd_o=3, wb_id_o=0; outstanding_o goes 1->0.
REQ-033 Scenario: issue 0x0000007B with accept=1, writeback=0 -> outstanding_o stays 0; no writeback.
REQ-034 Scenario: issue with accept=0 -> illegal_o pulses for 1 cycle; outstanding_o=0.
REQ-035 Scenario: 4 accepted issues with no results -> IDs 0,1,2,3 are used; instr_ready_o=0; a result for ID 2 -> next allocation is ID 2.
REQ-036 Scenario: result for ID 1 while ID 1 is free -> spurious_o pulses and wb_valid_o stays 0; with wb_ready_i=0 and wb full, x_result_ready_o=0.
REQ-037 Scenario: with CVXIF_ISSUE_TIMEOUT_EN defined, x_issue_ready_i held 0 -> timeout_o pulses 255 cycles after ISSUE entry; rst_i asserted mid-ISSUE -> all outputs reach reset values next cycle.
